// File: rtl/melody_sequencer_if.sv
// Bundle between the melody sequencer, its keypad/control front end and the
// melody recognizer. The sequencer connects through the slave modport; the
// environment (front end plus recognizer) connects through the master modport.
//   key_valid/key_tone/key_note : keyed note push strobe and payload
//   start/clear                 : playback request, FIFO flush request
//   rec_finish/rec_type         : recognizer status (rec_finish active-low)
//   rec_reset/rec_ok/rec_tone/rec_note : recognizer drive
//   busy/fifo_full/fifo_empty/overflow : sequencer status
//   result_valid/result_type/result_error : per-phrase classification
interface melody_sequencer_if;
  logic       key_valid;
  logic       key_tone;
  logic [2:0] key_note;
  logic       start;
  logic       clear;
  logic       rec_finish;
  logic [1:0] rec_type;
  logic       rec_reset;
  logic       rec_ok;
  logic       rec_tone;
  logic [2:0] rec_note;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       result_valid;
  logic [1:0] result_type;
  logic       result_error;

  modport master (
    output key_valid, key_tone, key_note, start, clear, rec_finish, rec_type,
    input  rec_reset, rec_ok, rec_tone, rec_note, busy, fifo_full, fifo_empty,
           overflow, result_valid, result_type, result_error
  );

  modport slave (
    input  key_valid, key_tone, key_note, start, clear, rec_finish, rec_type,
    output rec_reset, rec_ok, rec_tone, rec_note, busy, fifo_full, fifo_empty,
           overflow, result_valid, result_type, result_error
  );
endinterface

// File: rtl/melody_sequencer.sv
// Buffers keyed notes in a FIFO, replays them as ok-strobed note words into the
// melody recognizer, terminates the phrase with rests, polls for the result and
// reports one classification per phrase.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : melody_sequencer_if.slave (key input, control, recognizer, status, result)
// Build option: define MELODY_SEQ_REPLAY_EN to play through a separate pointer
// without popping, so the same phrase can be replayed until clear/reset.
module melody_sequencer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GAP       = 4,
  parameter int unsigned FLUSH_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  melody_sequencer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam int unsigned FW = $clog2(FLUSH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT, S_ISSUE, S_TERM, S_POLL_WAIT, S_POLL, S_DONE
  } state_e;

  state_e        state_q;
  logic [3:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] left_q;
  logic [GW-1:0] gap_q;
  logic [FW-1:0] flush_q;
  logic          rec_reset_q, rec_ok_q, rec_tone_q;
  logic [2:0]    rec_note_q;
  logic          busy_q, fifo_full_q, fifo_empty_q, overflow_q;
  logic          result_valid_q, result_error_q;
  logic [1:0]    result_type_q;
  logic          idle_c, clr_c, push_c, drop_c, pop_c, drain_c;
  logic [PW-1:0] head_c;
`ifdef MELODY_SEQ_REPLAY_EN
  logic [PW-1:0] play_ptr_q;
`endif

  // FIFO control: clear beats push; pushes outside IDLE or into a full FIFO are dropped
  always_comb begin
    idle_c = (state_q == S_IDLE);
    clr_c  = idle_c & bus.clear;
    push_c = idle_c & bus.key_valid & ~bus.clear & (count_q != CW'(DEPTH));
    drop_c = bus.key_valid & ~clr_c & ~push_c;
`ifdef MELODY_SEQ_REPLAY_EN
    pop_c   = 1'b0;
    drain_c = 1'b0;
    head_c  = play_ptr_q;
`else
    pop_c   = (state_q == S_ISSUE);
    drain_c = (state_q == S_WAIT) & ~bus.rec_finish;
    head_c  = rd_ptr_q;
`endif
    count_d = count_q;
    if (clr_c || drain_c) count_d = '0;
    else if (push_c)      count_d = count_q + CW'(1);
    else if (pop_c)       count_d = count_q - CW'(1);
  end

  // Note storage, not reset: contents are meaningless once the pointers are zeroed
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {bus.key_tone, bus.key_note};
  end

  // Pointers, status flags and playback FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      left_q         <= '0;
      gap_q          <= '0;
      flush_q        <= '0;
      rec_reset_q    <= 1'b1;
      rec_ok_q       <= 1'b0;
      rec_tone_q     <= 1'b0;
      rec_note_q     <= 3'd0;
      busy_q         <= 1'b0;
      fifo_full_q    <= 1'b0;
      fifo_empty_q   <= 1'b1;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_type_q  <= 2'd0;
      result_error_q <= 1'b0;
`ifdef MELODY_SEQ_REPLAY_EN
      play_ptr_q     <= '0;
`endif
    end else begin
      count_q        <= count_d;
      fifo_full_q    <= (count_d == CW'(DEPTH));
      fifo_empty_q   <= (count_d == '0);
      rec_reset_q    <= 1'b0;
      result_valid_q <= 1'b0;

      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drain_c) rd_ptr_q <= wr_ptr_q;
      if (clr_c) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        overflow_q <= 1'b0;
      end else if (drop_c) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start && count_q != '0) begin
            state_q     <= S_CLEAR;
            rec_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            left_q      <= count_q;
`ifdef MELODY_SEQ_REPLAY_EN
            play_ptr_q  <= rd_ptr_q;
`endif
          end
        end
        S_CLEAR: begin
          gap_q   <= GW'(GAP);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Recognizer finishing before the terminating rest aborts the phrase
          if (!bus.rec_finish) begin
            state_q        <= S_DONE;
            result_valid_q <= 1'b1;
            result_type_q  <= 2'd0;
            result_error_q <= 1'b1;
          end else if (gap_q == GW'(1)) begin
            rec_ok_q <= 1'b1;
            if (left_q != '0) begin
              {rec_tone_q, rec_note_q} <= mem_q[head_c];
              state_q <= S_ISSUE;
            end else begin
              {rec_tone_q, rec_note_q} <= 4'd0;
              flush_q <= FW'(1);
              state_q <= S_TERM;
            end
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        S_ISSUE: begin
          rec_ok_q <= 1'b0;
          left_q   <= left_q - CW'(1);
          gap_q    <= GW'(GAP);
          state_q  <= S_WAIT;
`ifdef MELODY_SEQ_REPLAY_EN
          play_ptr_q <= play_ptr_q + PW'(1);
`endif
        end
        S_TERM: begin
          rec_ok_q <= 1'b0;
          gap_q    <= GW'(GAP);
          state_q  <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (gap_q == GW'(1)) begin
            if (!bus.rec_finish) begin
              state_q        <= S_DONE;
              result_valid_q <= 1'b1;
              result_type_q  <= bus.rec_type;
              result_error_q <= (bus.rec_type == 2'd0);
            end else if (flush_q == FW'(FLUSH_MAX)) begin
              state_q        <= S_DONE;
              result_valid_q <= 1'b1;
              result_type_q  <= 2'd0;
              result_error_q <= 1'b1;
            end else begin
              rec_ok_q                 <= 1'b1;
              {rec_tone_q, rec_note_q} <= 4'd0;
              state_q                  <= S_POLL;
            end
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        S_POLL: begin
          rec_ok_q <= 1'b0;
          if (flush_q != FW'(FLUSH_MAX)) flush_q <= flush_q + FW'(1);
          gap_q    <= GW'(GAP);
          state_q  <= S_POLL_WAIT;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rec_reset    = rec_reset_q;
  assign bus.rec_ok       = rec_ok_q;
  assign bus.rec_tone     = rec_tone_q;
  assign bus.rec_note     = rec_note_q;
  assign bus.busy         = busy_q;
  assign bus.fifo_full    = fifo_full_q;
  assign bus.fifo_empty   = fifo_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_type  = result_type_q;
  assign bus.result_error = result_error_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed testbench for melody_sequencer with a small scripted recognizer model.
module tb_melody_sequencer;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned GAP       = 4;
  localparam int unsigned FLUSH_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  melody_sequencer_if bus();

  melody_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .FLUSH_MAX(FLUSH_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int res_cnt = 0;
  int ok_cnt = 0;
  int finish_after = 0;
  logic [1:0] model_type = 2'd0;
  int pulse_cyc [32];
  logic [3:0] pulse_val [32];

  // Recognizer stand-in: reports finish with model_type after finish_after ok pulses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.start === 1'b1) start_cyc <= cyc;
    if (bus.result_valid === 1'b1) res_cnt <= res_cnt + 1;
    if (bus.rec_reset === 1'b1) begin
      ok_cnt         <= 0;
      bus.rec_finish <= 1'b1;
      bus.rec_type   <= 2'd0;
    end else if (bus.rec_ok === 1'b1) begin
      ok_cnt <= ok_cnt + 1;
      if (ok_cnt < 32) begin
        pulse_cyc[ok_cnt] <= cyc;
        pulse_val[ok_cnt] <= {bus.rec_tone, bus.rec_note};
      end
      if (ok_cnt + 1 == finish_after) begin
        bus.rec_finish <= 1'b0;
        bus.rec_type   <= model_type;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic t, input logic [2:0] n);
    bus.key_valid = 1'b1; bus.key_tone = t; bus.key_note = n;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic do_start(input int fa, input logic [1:0] mt);
    finish_after = fa; model_type = mt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [1:0] etype, input logic eerr);
    int n;
    n = 0;
    while (bus.result_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_type"}, 32'(bus.result_type), 32'(etype));
    chk({tag, "_error"}, 32'(bus.result_error), 32'(eerr));
    @(negedge clk);
    chk({tag, "_pulse_once"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic key_phrase(input logic [3:0] second);
    key(1'b0, 3'b100);
    key(second[3], second[2:0]);
    key(1'b0, 3'b010);
    key(1'b0, 3'b011);
    key(1'b0, 3'b101);
  endtask

  initial begin
    int seen;
    int n;
    logic exp_empty;
    int saved;
`ifdef MELODY_SEQ_REPLAY_EN
    exp_empty = 1'b0;
`else
    exp_empty = 1'b1;
`endif
    bus.key_valid = 1'b0; bus.key_tone = 1'b0; bus.key_note = 3'd0;
    bus.start = 1'b0; bus.clear = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rec_reset", 32'(bus.rec_reset), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_rec_ok", 32'(bus.rec_ok), 32'd0);
    chk("rst_result", 32'({bus.result_valid, bus.result_type, bus.result_error}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rec_reset_drop", 32'(bus.rec_reset), 32'd0);

    // Test 1: past-tense phrase, TERM plus one poll
    key_phrase({1'b1, 3'b001});
    chk("t1_not_empty", 32'(bus.fifo_empty), 32'd0);
    do_start(7, 2'b01);
    wait_result("t1", 2'b01, 1'b0);
    chk("t1_ok_count", 32'(ok_cnt), 32'd7);
    chk("t1_latency", 32'(pulse_cyc[0] - start_cyc), 32'(GAP + 2));
    for (int i = 0; i < 6; i++)
      chk("t1_spacing", 32'(pulse_cyc[i+1] - pulse_cyc[i]), 32'(GAP + 1));
    chk("t1_note0", 32'(pulse_val[0]), 32'h4);
    chk("t1_note1", 32'(pulse_val[1]), 32'h9);
    chk("t1_note4", 32'(pulse_val[4]), 32'h5);
    chk("t1_term", 32'(pulse_val[5]), 32'h0);
    chk("t1_poll", 32'(pulse_val[6]), 32'h0);
    chk("t1_empty_after", 32'(bus.fifo_empty), 32'(exp_empty));

    // Test 2: infinitive and future phrases
    do_clear();
    key_phrase({1'b1, 3'b100});
    do_start(7, 2'b10);
    wait_result("t2a", 2'b10, 1'b0);
    do_clear();
    key_phrase({1'b1, 3'b111});
    do_start(7, 2'b11);
    wait_result("t2b", 2'b11, 1'b0);
    chk("t2b_note1", 32'(pulse_val[1]), 32'hF);

    // Recognizer finishing with class none flags an error
    do_clear();
    key_phrase({1'b1, 3'b001});
    do_start(7, 2'b00);
    wait_result("t2c", 2'b00, 1'b1);

    // Test 3: early finish after the first note aborts and drains
    do_clear();
    key(1'b0, 3'b001);
    key(1'b1, 3'b001); key(1'b0, 3'b010); key(1'b0, 3'b011); key(1'b0, 3'b101);
    do_start(1, 2'b01);
    wait_result("t3", 2'b00, 1'b1);
    chk("t3_ok_count", 32'(ok_cnt), 32'd1);
    chk("t3_empty", 32'(bus.fifo_empty), 32'(exp_empty));

    // Test 4: recognizer never finishes -> FLUSH_MAX rests then timeout
    do_clear();
    key_phrase({1'b1, 3'b001});
    do_start(0, 2'b01);
    wait_result("t4", 2'b00, 1'b1);
    chk("t4_ok_count", 32'(ok_cnt), 32'(5 + FLUSH_MAX));
    chk("t4_last_rest", 32'(pulse_val[8]), 32'h0);
    chk("t4_spacing", 32'(pulse_cyc[8] - pulse_cyc[7]), 32'(GAP + 1));

    // Test 5: overflow, clear priority, drop while busy
    do_clear();
    for (int i = 0; i < DEPTH; i++) key(1'b0, 3'(i % 7 + 1));
    chk("t5_full", 32'(bus.fifo_full), 32'd1);
    chk("t5_no_ovf_yet", 32'(bus.overflow), 32'd0);
    key(1'b1, 3'b111);
    chk("t5_overflow", 32'(bus.overflow), 32'd1);
    chk("t5_still_full", 32'(bus.fifo_full), 32'd1);
    bus.clear = 1'b1; bus.key_valid = 1'b1; bus.key_note = 3'b011;
    @(negedge clk);
    bus.clear = 1'b0; bus.key_valid = 1'b0;
    chk("t5_clear_wins", 32'(bus.fifo_empty), 32'd1);
    chk("t5_ovf_cleared", 32'(bus.overflow), 32'd0);
    key(1'b0, 3'b001);
    do_start(3, 2'b01);
    key(1'b0, 3'b010);
    chk("t5_busy_drop", 32'(bus.overflow), 32'd1);
    wait_result("t5", 2'b01, 1'b0);
    chk("t5_ok_count", 32'(ok_cnt), 32'd3);
    chk("t5_empty_after", 32'(bus.fifo_empty), 32'(exp_empty));

    // Test 6: reset during the third rec_ok pulse
    do_clear();
    key_phrase({1'b1, 3'b001});
    saved = res_cnt;
    do_start(7, 2'b01);
    seen = 0; n = 0;
    while (seen < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.rec_ok === 1'b1) seen++;
    end
    chk("t6_third_ok", 32'(seen), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_empty", 32'(bus.fifo_empty), 32'd1);
    chk("t6_rec_reset", 32'(bus.rec_reset), 32'd1);
    chk("t6_rec_ok", 32'(bus.rec_ok), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_no_result", 32'(res_cnt), 32'(saved));

`ifdef MELODY_SEQ_REPLAY_EN
    // Replay: same phrase twice, entries retained
    key_phrase({1'b1, 3'b001});
    do_start(7, 2'b01);
    wait_result("r1", 2'b01, 1'b0);
    chk("r1_kept", 32'(bus.fifo_empty), 32'd0);
    do_start(7, 2'b01);
    wait_result("r2", 2'b01, 1'b0);
    chk("r2_ok_count", 32'(ok_cnt), 32'd7);
    chk("r2_note0", 32'(pulse_val[0]), 32'h4);
    chk("r2_kept", 32'(bus.fifo_empty), 32'd0);
    chk("r2_not_full", 32'(bus.fifo_full), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
